mdu_alu: RTL and testbench
==========================

Name: mdu_alu

Overview:
- Parametrised next-generation execute unit for the MIPS datapath.
- Keeps the single-cycle combinational ALU operation set at generic WIDTH.
- Adds a sequential multiply/divide engine (MULT/MULTU/DIV/DIVU) with HI/LO registers, start/busy/done handshake, and MFHI/MFLO/MTHI/MTLO support.
- Sits in EX stage; hazard unit stalls on busy.

Parameters:
- WIDTH, 32: datapath width; must be >= 8 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in1  in  WIDTH  operand A; shift amount in in1[SHW-1:0]; dividend/multiplicand.
- in2  in  WIDTH  operand B; shifted value; divisor/multiplier.
- ALUCtl  in  5  operation select.
- Sign  in  1  1 = signed compare/multiply/divide.
- start  in  1  launch MULT/DIV/MTHI/MTLO selected by ALUCtl.
- out  out  WIDTH  combinational result.
- zero  out  1  out == 0.
- busy  out  1  multi-cycle engine running.
- done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:

Combinational ops (out), valid regardless of busy:
- 00000 AND
- 00001 OR
- 00010 ADD (mod 2^WIDTH)
- 00110 SUB
- 00111 SLT: zero-extended 1 bit; signed when Sign, else unsigned
- 01100 NOR
- 01101 XOR
- 10000 SLL: in2 << in1[SHW-1:0]
- 11000 SRL
- 11001 SRA: sign-fill
- 10100 MFHI: out = hi
- 10101 MFLO: out = lo
- default: 0
- During busy, MFHI/MFLO return the current (old) register contents.

Sequential ops (take effect only when start=1 and busy=0 at a rising edge):
- 11100 MUL: Sign selects MULT/MULTU.
- 11101 DIV: Sign selects DIV/DIVU.
- 11110 MTHI: hi <= in1 at that edge; no busy, no done.
- 11111 MTLO: lo <= in1 at that edge; no busy, no done.
- start with any other ALUCtl: ignored.
- start while busy=1: ignored entirely, no queuing. HI/LO and in-flight operation unaffected.

FSM states: IDLE, RUN, FIX.
- IDLE -> RUN on accepted MUL/DIV.
  - Latch operand magnitudes (two's-complement abs when Sign), result-sign flags and op type.
  - Clear iteration counter.
- RUN: one iteration per cycle, exactly WIDTH cycles, then -> FIX.
  - MUL: shift-add, 2*WIDTH-bit accumulator.
  - DIV: restoring divide, one quotient bit per cycle.
- FIX: one cycle.
  - Apply sign correction, write hi/lo, -> IDLE.
  - done=1 for the cycle following this edge.

Timing (start accepted at edge 0):
- busy=1 after edge 0 through edge WIDTH+1.
- hi/lo hold new values after edge WIDTH+1. Total latency WIDTH+1 cycles.
- done=1 only in cycle WIDTH+1..WIDTH+2.
- A new start may be accepted at edge WIDTH+1? No: busy is high until that edge completes. The earliest new accept is edge WIDTH+2, which coincides with the done cycle.

Results:
- MUL: {hi,lo} = full 2*WIDTH-bit product.
  - Signed product negative iff operand signs differ and neither operand is 0.
- DIV: lo = quotient truncated toward zero, hi = remainder.
  - Signed remainder takes the sign of the dividend.
- Signed most-negative / -1: lo = most-negative, hi = 0. No trap.
- Divide by zero:
  - lo = all ones, hi = in1 (as latched), both for signed and unsigned.
  - Still takes full latency; done pulses.
- Operands are latched at accept; in1/in2 may change during RUN.

Reset (reset=0, any time, including mid-RUN/FIX):
- FSM -> IDLE; operation aborted.
- busy=0, done=0, hi=0, lo=0; counter and accumulators cleared.
- out and zero remain combinational.

Test Plan:
1. Combinational sweep, WIDTH=32:
   - SLT Sign=1, in1=FFFFFFFF, in2=1 -> out=1.
   - Sign=0 -> out=0.
   - SRA in1=4, in2=80000000 -> out=F8000000.
   - SUB 5-5 -> out=0, zero=1.
2. MULT Sign=1, in1=FFFFFFFE (-2), in2=3 with start at edge 0:
   - busy=1 for 33 cycles.
   - done pulses once.
   - hi=FFFFFFFF, lo=FFFFFFFA.
   - MULTU with the same operands: hi=00000002, lo=FFFFFFFA.
3. DIV Sign=1, in1=FFFFFFF9 (-7), in2=2:
   - lo=FFFFFFFD, hi=FFFFFFFF.
   - 80000000/FFFFFFFF: lo=80000000, hi=0.
   - DIVU 7/0: lo=FFFFFFFF, hi=7.
4. Handshake:
   - start DIV while busy with MUL -> ignored; MUL result intact.
   - MTHI during busy -> hi unchanged.
   - MFLO during busy returns old lo.
   - Back-to-back start in the done cycle is accepted.
5. Reset mid-RUN:
   - Drive reset=0 asynchronously at cycle 10 of a MULT -> busy/hi/lo=0 immediately.
   - After release, no done pulse.
   - A new MULT 6*7 gives lo=2A, hi=0.
6. Parameter check, WIDTH=8:
   - MULTU FF*FF -> hi=FE, lo=01; latency 9 cycles.
   - SLL in1=9 uses in1[2:0]=1 -> shift by 1.

Source files
------------

// File: rtl/mdu_alu.sv
// mdu_alu: EX-stage execute unit. Single-cycle combinational ALU plus a
// sequential multiply/divide engine (shift-add / restoring) that owns the HI/LO
// registers and exposes a start/busy/done handshake.
module mdu_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       ALUCtl,
  input  logic             Sign,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MUL  = 5'b11100;
  localparam logic [4:0] OP_DIV  = 5'b11101;
  localparam logic [4:0] OP_MTHI = 5'b11110;
  localparam logic [4:0] OP_MTLO = 5'b11111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [SHW-1:0]       shamt;
  logic                 slt;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       rem_sh;
  logic                 ge;
  logic [WIDTH-1:0]     rem_nx;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     quo, rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign shamt = in1[SHW-1:0];
  assign slt   = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
  assign a_mag = mag(in1, Sign);
  assign b_mag = mag(in2, Sign);

  // Multiply iteration: conditionally add multiplicand into the upper half,
  // then shift the whole accumulator right (carry enters at the top).
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide iteration: remainder in the upper half, dividend/quotient in the
  // lower half. The trial difference always fits WIDTH bits when it is taken.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, opnd_q};
  assign rem_nx   = ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
  assign div_step = {rem_nx, acc_q[WIDTH-2:0], ge};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  // Combinational ALU result; MFHI/MFLO read the committed registers.
  always_comb begin
    out = '0;
    case (ALUCtl)
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  out = ~(in1 | in2);
      OP_XOR:  out = in1 ^ in2;
      OP_SLL:  out = in2 << shamt;
      OP_SRL:  out = in2 >> shamt;
      OP_SRA:  out = $unsigned($signed(in2) >>> shamt);
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Engine state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept MUL/DIV only when idle, WIDTH iterations, one fix-up cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (ALUCtl == OP_MUL || ALUCtl == OP_DIV)) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand latch, iteration, sign fix-up and HI/LO writes.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == S_FIX);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ALUCtl)
            OP_MUL, OP_DIV: begin
              is_div_d = (ALUCtl == OP_DIV);
              cnt_d    = '0;
              opnd_d   = (ALUCtl == OP_DIV) ? b_mag : a_mag;
              acc_d    = {{WIDTH{1'b0}}, ((ALUCtl == OP_DIV) ? a_mag : b_mag)};
              neg_q_d  = Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_r_d  = Sign & in1[WIDTH-1];
              dz_d     = (in2 == '0);
            end
            OP_MTHI: hi_d = in1;
            OP_MTLO: lo_d = in1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        // Divide by zero leaves |dividend| as remainder; re-applying the
        // dividend sign restores the original in1, so only lo needs overriding.
        if (is_div_q) begin
          lo_d = dz_q ? '1 : (neg_q_q ? -quo : quo);
          hi_d = neg_r_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q_q ? -acc_q : acc_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// tb_mdu_alu: directed bench for mdu_alu at WIDTH=32 (cycle-checked against a
// behavioural model) and WIDTH=8 (directed literal checks).
module tb_mdu_alu;

  localparam logic [4:0] C_AND  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00010;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SLT  = 5'b00111;
  localparam logic [4:0] C_NOR  = 5'b01100;
  localparam logic [4:0] C_XOR  = 5'b01101;
  localparam logic [4:0] C_SLL  = 5'b10000;
  localparam logic [4:0] C_SRL  = 5'b11000;
  localparam logic [4:0] C_SRA  = 5'b11001;
  localparam logic [4:0] C_MFHI = 5'b10100;
  localparam logic [4:0] C_MFLO = 5'b10101;
  localparam logic [4:0] C_MUL  = 5'b11100;
  localparam logic [4:0] C_DIV  = 5'b11101;
  localparam logic [4:0] C_MTHI = 5'b11110;
  localparam logic [4:0] C_MTLO = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2, out, hi, lo;
  logic [4:0]  ctl;
  logic        sgn, start, zero, busy, done;

  logic [7:0]  a8, b8, out8, hi8, lo8;
  logic [4:0]  ctl8;
  logic        sgn8, st8, zero8, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .in1(in1), .in2(in2), .ALUCtl(ctl), .Sign(sgn),
    .start(start), .out(out), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst_n), .in1(a8), .in2(b8), .ALUCtl(ctl8), .Sign(sgn8),
    .start(st8), .out(out8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (WIDTH=32) ----------------
  function automatic logic [31:0] exp_out(input logic [4:0] c, input logic s,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
    case (c)
      C_AND:  return a & b;
      C_OR:   return a | b;
      C_ADD:  return a + b;
      C_SUB:  return a - b;
      C_SLT:  return s ? {31'b0, ($signed(a) < $signed(b))} : {31'b0, (a < b)};
      C_NOR:  return ~(a | b);
      C_XOR:  return a ^ b;
      C_SLL:  return b << a[4:0];
      C_SRL:  return b >> a[4:0];
      C_SRA:  return $unsigned($signed(b) >>> a[4:0]);
      C_MFHI: return h;
      C_MFLO: return l;
      default: return 32'h0;
    endcase
  endfunction

  // Returns {hi, lo} for MUL/DIV using native arithmetic.
  function automatic logic [63:0] exp_md(input logic is_div, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sp;
    if (!is_div) begin
      if (s) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    end
    return {a % b, a / b};
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_rem;
  logic [63:0] m_pend;

  // Model: accepted MUL/DIV commits WIDTH+1 edges later, done follows the commit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_rem <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_done <= 1'b1;
        end
      end else if (start) begin
        if (ctl == C_MUL || ctl == C_DIV) begin
          m_pend <= exp_md(ctl == C_DIV, sgn, in1, in2);
          m_rem  <= 33;
        end else if (ctl == C_MTHI) m_hi <= in1;
        else if (ctl == C_MTLO) m_lo <= in1;
      end
    end
  end

  // Per-cycle compare of every WIDTH=32 output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out",  out,  exp_out(ctl, sgn, in1, in2, m_hi, m_lo));
      check("zero", zero, exp_out(ctl, sgn, in1, in2, m_hi, m_lo) == 32'h0);
      check("busy", busy, m_rem != 0);
      check("done", done, m_done);
      check("hi",   hi,   m_hi);
      check("lo",   lo,   m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic st);
    ctl = c; sgn = s; in1 = a; in2 = b; start = st;
  endtask

  task automatic run_md(input logic [4:0] c, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    drive(c, s, a, b, 1'b1);
    step();
    start = 1'b0;
    check("accept", busy, 1'b1);
    lat = 1;
    while (busy === 1'b1 && lat < 100) begin
      step();
      if (busy === 1'b1) lat++;
    end
    check("done_pulse", done, 1'b1);
  endtask

  task automatic run8(input logic [4:0] c, input logic s, input logic [7:0] a,
                      input logic [7:0] b, output int lat);
    ctl8 = c; sgn8 = s; a8 = a; b8 = b; st8 = 1'b1;
    step();
    st8 = 1'b0;
    lat = 1;
    while (busy8 === 1'b1 && lat < 100) begin
      step();
      if (busy8 === 1'b1) lat++;
    end
    check("done8", done8, 1'b1);
  endtask

  logic [4:0]  sw_ops [12] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR,
                               C_XOR, C_SLL, C_SRL, C_SRA, C_MFHI, 5'b00011};
  logic [31:0] sw_a [3] = '{32'hF0F0_1234, 32'h0000_001F, 32'h8000_0000};
  logic [31:0] sw_b [3] = '{32'h0FF0_8765, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

  initial begin
    int lat;
    int dcnt;
    rst_n = 1'b1;
    drive(C_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    ctl8 = C_AND; sgn8 = 1'b0; a8 = '0; b8 = '0; st8 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy8", busy8, 1'b0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    step();

    // Combinational ops
    drive(C_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 check("slt_signed", out, 32'h1); step();
    drive(C_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 check("slt_unsigned", out, 32'h0); step();
    drive(C_SRA, 1'b0, 32'h4, 32'h8000_0000, 1'b0); #1 check("sra", out, 32'hF800_0000); step();
    drive(C_SUB, 1'b0, 32'h5, 32'h5, 1'b0); #1 check("sub_zero", {zero, out}, {1'b1, 32'h0}); step();
    drive(C_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0); #1 check("add_wrap", {zero, out}, {1'b1, 32'h0}); step();
    drive(C_SLL, 1'b0, 32'h24, 32'h3, 1'b0); #1 check("sll_shamt", out, 32'h30); step();
    for (int s = 0; s < 2; s++)
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 12; i++) begin
          drive(sw_ops[i], s[0], sw_a[j], sw_b[j], 1'b0);
          step();
        end

    // Multiply
    run_md(C_MUL, 1'b1, 32'hFFFF_FFFE, 32'h3, lat);
    check("mult_lat", lat, 33);
    check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md(C_MUL, 1'b0, 32'hFFFF_FFFE, 32'h3, lat);
    check("multu_res", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_md(C_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, lat);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    run_md(C_MUL, 1'b1, 32'h0, 32'hFFFF_FFFF, lat);
    check("mult_zero", {hi, lo}, 64'h0);

    // Divide
    run_md(C_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, lat);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(C_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_md(C_DIV, 1'b1, 32'h7, 32'hFFFF_FFFE, lat);
    check("div_pos_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_md(C_DIV, 1'b0, 32'hFFFF_FFF9, 32'h10, lat);
    check("divu", {hi, lo}, 64'h0000_0009_0FFF_FFFF);
    run_md(C_DIV, 1'b1, 32'hFFFF_FFFB, 32'h0, lat);
    check("div_by0_s", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    run_md(C_DIV, 1'b0, 32'h7, 32'h0, lat);
    check("divu_by0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    check("divu_by0_lat", lat, 33);

    // Handshake: starts while busy are ignored, MFLO returns old lo
    drive(C_MUL, 1'b0, 32'h6, 32'h7, 1'b1); step(); start = 1'b0;
    repeat (4) step();
    drive(C_DIV, 1'b1, 32'h64, 32'h3, 1'b1); step(); start = 1'b0;
    drive(C_MTHI, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1); step(); start = 1'b0;
    check("mthi_busy", hi, 32'h7);
    drive(C_MFLO, 1'b0, 32'h0, 32'h0, 1'b0); #1 check("mflo_busy", out, 32'hFFFF_FFFF);
    dcnt = 0;
    while (busy === 1'b1 && dcnt < 100) begin step(); dcnt++; end
    check("hs_done", done, 1'b1);
    check("hs_res", {hi, lo}, 64'h0000_0000_0000_002A);
    run_md(C_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("b2b_res", {hi, lo}, 64'h0000_0000_0000_0001);
    step();
    drive(C_MTHI, 1'b0, 32'h1234_5678, 32'h0, 1'b1); step(); start = 1'b0;
    check("mthi", {busy, hi}, {1'b0, 32'h1234_5678});
    drive(C_MTLO, 1'b0, 32'h9ABC_DEF0, 32'h0, 1'b1); step(); start = 1'b0;
    check("mtlo", {busy, lo}, {1'b0, 32'h9ABC_DEF0});
    step();

    // Asynchronous reset mid-RUN
    drive(C_MUL, 1'b1, 32'hFFFF_FFFE, 32'h3, 1'b1); step(); start = 1'b0;
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1 check("arst_state", {busy, done, hi, lo}, {2'b00, 64'h0});
    step();
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin step(); if (done === 1'b1) dcnt++; end
    check("arst_no_done", dcnt, 0);
    run_md(C_MUL, 1'b1, 32'h6, 32'h7, lat);
    check("arst_mult", {hi, lo}, 64'h0000_0000_0000_002A);
    check("arst_lat", lat, 33);
    drive(C_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // WIDTH=8 instance
    run8(C_MUL, 1'b0, 8'hFF, 8'hFF, lat);
    check("w8_lat", lat, 9);
    check("w8_multu", {hi8, lo8}, 16'hFE01);
    run8(C_DIV, 1'b0, 8'hC8, 8'h07, lat);
    check("w8_divu", {hi8, lo8}, 16'h041C);
    run8(C_DIV, 1'b1, 8'h80, 8'hFF, lat);
    check("w8_div_ovf", {hi8, lo8}, 16'h0080);
    run8(C_MUL, 1'b1, 8'hFE, 8'h03, lat);
    check("w8_mult", {hi8, lo8}, 16'hFFFA);
    ctl8 = C_SLL; a8 = 8'h09; b8 = 8'h41; #1 check("w8_sll", out8, 8'h82); step();
    ctl8 = C_SRA; a8 = 8'h0B; b8 = 8'h80; #1 check("w8_sra", out8, 8'hF0); step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
